// File: rtl/ledr_drv_pkg.sv
// Shared constants and helpers for the LEDR PWM output driver.
package ledr_drv_pkg;

  localparam int LED_WIDTH = 18;
  localparam int PWM_BITS = 8;
  localparam logic [PWM_BITS-1:0] BRIGHT_FULL = 8'hFF;

  localparam int DEF_PRESCALE = 195;
  localparam int DEF_BLINK_FRAMES = 500;

  typedef logic [PWM_BITS-1:0] pwm_t;

  // Counter width for a modulo-n counter, never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ledr_pwm_timebase.sv
// PWM timebase: prescaler, 8-bit duty counter and registered frame pulse.
module ledr_pwm_timebase
  import ledr_drv_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  output pwm_t pwm_cnt_o,
  output logic frame_start_o
);

  localparam int PW = cnt_w(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;
  pwm_t          pwm_q, pwm_d;
  logic          fs_q, fs_d;
  logic          step;

  always_comb begin
    step  = (pre_q == PRE_LAST);
    pre_d = step ? '0 : pre_q + 1'b1;
    pwm_d = step ? pwm_q + 1'b1 : pwm_q;
    // Pulse follows the 255 -> 0 wrap by one register stage.
    fs_d  = step && (pwm_q == BRIGHT_FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
      pwm_q <= '0;
      fs_q  <= 1'b0;
    end else begin
      pre_q <= pre_d;
      pwm_q <= pwm_d;
      fs_q  <= fs_d;
    end
  end

  assign pwm_cnt_o     = pwm_q;
  assign frame_start_o = fs_q;

endmodule

// File: rtl/nios_sys_ledr_pwm_driver.sv
// LEDR output stage: frame-synchronous shadowing, global PWM dimming and
// masked blinking, with a registered pin drive.
module nios_sys_ledr_pwm_driver
  import ledr_drv_pkg::*;
#(
  parameter int WIDTH        = LED_WIDTH,
  parameter int PRESCALE     = DEF_PRESCALE,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_pattern,
  input  pwm_t             brightness,
  input  logic [WIDTH-1:0] blink_mask,
  input  logic             blink_en,
  output logic [WIDTH-1:0] led_out,
  output logic             frame_start
);

  localparam int FW = cnt_w(BLINK_FRAMES);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  pwm_t             pwm_cnt;
  logic             fs;

  logic [WIDTH-1:0] pat_q, msk_q;
  pwm_t             bri_q;
  logic             ben_q;
  logic [FW-1:0]    frm_q, frm_d;
  logic             ph_q, ph_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             pwm_on, blank;

  ledr_pwm_timebase #(
    .PRESCALE(PRESCALE)
  ) u_tb (
    .clk          (clk),
    .reset        (reset),
    .pwm_cnt_o    (pwm_cnt),
    .frame_start_o(fs)
  );

  always_comb begin
    frm_d = frm_q;
    ph_d  = ph_q;
    if (fs) begin
      if (frm_q == FRM_LAST) begin
        frm_d = '0;
        ph_d  = ~ph_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end
  end

  // Full scale is forced on so 255 gives no dark step per frame.
  always_comb begin
    pwm_on = (bri_q == BRIGHT_FULL) | (pwm_cnt < bri_q);
    blank  = ben_q & ph_q;
    led_d  = pat_q & {WIDTH{pwm_on}} & ~({WIDTH{blank}} & msk_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q <= '0;
      msk_q <= '0;
      bri_q <= '0;
      ben_q <= 1'b0;
      frm_q <= '0;
      ph_q  <= 1'b0;
      led_q <= '0;
    end else begin
      if (fs) begin
        pat_q <= in_pattern;
        msk_q <= blink_mask;
        bri_q <= brightness;
        ben_q <= blink_en;
      end
      frm_q <= frm_d;
      ph_q  <= ph_d;
      led_q <= led_d;
    end
  end

  assign led_out     = led_q;
  assign frame_start = fs;

endmodule

// File: tb/tb_nios_sys_ledr_pwm_driver.sv
// Scoreboard bench for the LEDR PWM driver with a time-indexed reference model.
module tb_nios_sys_ledr_pwm_driver;

  localparam int P  = 2;
  localparam int BF = 2;
  localparam int W  = 18;
  localparam int F  = 256 * P;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] in_pattern = '0;
  logic [7:0]   brightness = '0;
  logic [W-1:0] blink_mask = '0;
  logic         blink_en = 1'b0;
  logic [W-1:0] led_out;
  logic         frame_start;

  always #5 clk = ~clk;

  nios_sys_ledr_pwm_driver #(
    .WIDTH(W),
    .PRESCALE(P),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_pattern (in_pattern),
    .brightness (brightness),
    .blink_mask (blink_mask),
    .blink_en   (blink_en),
    .led_out    (led_out),
    .frame_start(frame_start)
  );

  typedef struct {
    logic [W-1:0] led;
    logic         fs;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 0;

  // Stimulus values applied at the next falling edge
  logic [W-1:0] c_pat = '0, c_msk = '0;
  logic [7:0]   c_bri = '0;
  logic         c_ben = 1'b0, c_rst = 1'b1;

  // Reference model state: k = rising edges since reset release
  int           k;
  bit           m_fs;
  int           nloads;
  logic [W-1:0] s_pat, s_msk;
  logic [7:0]   s_bri;
  logic         s_ben;

  task automatic model_reset();
    k = 0;
    m_fs = 0;
    nloads = 0;
    s_pat = '0;
    s_msk = '0;
    s_bri = '0;
    s_ben = 1'b0;
  endtask

  task automatic step_model();
    exp_t x;
    int   pwm;
    bit   on, blank;
    if (reset) begin
      model_reset();
      x.led = '0;
      x.fs  = 1'b0;
    end else begin
      pwm   = (k / P) % 256;
      on    = (s_bri == 8'hFF) || (pwm < int'(s_bri));
      blank = s_ben && (((nloads / BF) % 2) == 1);
      x.led = on ? (s_pat & ~(blank ? s_msk : '0)) : '0;
      if (m_fs) begin
        s_pat = in_pattern;
        s_bri = brightness;
        s_msk = blink_mask;
        s_ben = blink_en;
        nloads++;
      end
      k++;
      m_fs = (k % F) == 0;
      x.fs = m_fs;
    end
    q.push_back(x);
    mon_en = 1;
  endtask

  task automatic cyc();
    @(negedge clk);
    in_pattern = c_pat;
    brightness = c_bri;
    blink_mask = c_msk;
    blink_en   = c_ben;
    reset      = c_rst;
    @(posedge clk);
    step_model();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_in(input logic [W-1:0] p, input logic [7:0] b,
                        input logic [W-1:0] m, input logic e);
    c_pat = p;
    c_bri = b;
    c_msk = m;
    c_ben = e;
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL queue_empty t=%0t", $time);
        end else begin
          x = q.pop_front();
          if (led_out !== x.led) begin
            failures++;
            $display("FAIL led_out t=%0t got=%05h exp=%05h",
                     $time, led_out, x.led);
          end
          checks++;
          if (frame_start !== x.fs) begin
            failures++;
            $display("FAIL frame_start t=%0t got=%0b exp=%0b",
                     $time, frame_start, x.fs);
          end
        end
      end
    end
  end

  initial begin
    int guard;
    model_reset();

    // Reset, then idle
    c_rst = 1'b1;
    run(3);
    c_rst = 1'b0;
    run(2 * F + 10);

    // 25% duty on all LEDs
    set_in(18'h3FFFF, 8'd64, '0, 1'b0);
    run(3 * F);

    // Brightness extremes
    set_in(18'h3FFFF, 8'd0, '0, 1'b0);
    run(2 * F);
    set_in(18'h3FFFF, 8'd255, '0, 1'b0);
    run(2 * F);

    // Mid-frame change is deferred to the next frame
    set_in(18'h00001, 8'd255, '0, 1'b0);
    run(F + F / 2);
    set_in(18'h20000, 8'd255, '0, 1'b0);
    run(F);

    // Change presented on the exact frame_start edge is taken
    set_in(18'h00001, 8'd255, '0, 1'b0);
    guard = 0;
    while (!m_fs && guard < 2 * F) begin
      cyc();
      guard++;
    end
    run(F);
    guard = 0;
    while (!m_fs && guard < 2 * F) begin
      cyc();
      guard++;
    end
    set_in(18'h20000, 8'd255, '0, 1'b0);
    run(F);

    // Masked blinking
    set_in(18'h000FF, 8'd255, 18'h0000F, 1'b1);
    run(6 * F);

    // Randomized inputs changing at random instants
    for (int i = 0; i < 4 * F; i++) begin
      if ($urandom_range(0, 199) == 0 || i == 0)
        set_in(W'($urandom), 8'($urandom), W'($urandom), 1'($urandom));
      cyc();
    end

    // Asynchronous reset while LEDs are lit
    set_in(18'h3FFFF, 8'd255, '0, 1'b0);
    run(F + F / 2);
    #2;
    reset = 1'b1;
    c_rst = 1'b1;
    #1;
    checks++;
    if (led_out !== '0 || frame_start !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got_led=%05h got_fs=%0b exp=0",
               led_out, frame_start);
    end
    run(3);
    c_rst = 1'b0;
    run(2 * F + 10);

    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
